// File: rtl/router_pkg.sv
// Shared constants and types for the router output-port reader.
package router_pkg;

  localparam int HDR_LEN_MSB     = 7;
  localparam int HDR_LEN_LSB     = 2;
  localparam int HDR_ADDR_MSB    = 1;
  localparam int DEFAULT_TIMEOUT = 30;
  localparam int LEN_W           = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PLD = 2'd1,
    PAR = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic       tag;
    logic       mismatch;
    logic [7:0] data;
  } buf_entry_t;

endpackage

// File: rtl/router_out_port_skid.sv
// Two-entry in-order holding buffer between the FIFO read port and the client.
module out_skid_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  buf_entry_t i_entry,
  output buf_entry_t o_head,
  output logic [1:0] o_held
);

  buf_entry_t r_mem [2];
  logic       r_rd_ptr;
  logic [1:0] r_held;
  logic       w_wr_ptr;

  // With two slots the tail sits one past the head whenever exactly one entry is held.
  assign w_wr_ptr = r_rd_ptr ^ r_held[0];
  assign o_head   = r_mem[r_rd_ptr];
  assign o_held   = r_held;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_held   <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_held   <= 2'd0;
    end else begin
      if (i_push) r_mem[w_wr_ptr] <= i_entry;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_held <= r_held + 2'd1;
        2'b01:   r_held <= r_held - 2'd1;
        default: r_held <= r_held;
      endcase
    end
  end

endmodule

// File: rtl/router_out_port.sv
// Output-port reader: issues FIFO reads, re-frames packets, checks parity and
// fires soft_reset when the client stalls too long.
module router_out_port
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_en,
  output logic       soft_reset,
  input  logic       read_enb,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       pkt_done,
  output logic       parity_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  logic             r_inflight;
  logic             r_soft_reset;
  logic             r_pkt_done;
  logic             r_parity_err;
  logic [CNT_W-1:0] r_cnt;
  frame_state_t     r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [7:0]       r_acc;

  logic [1:0]       w_held;
  buf_entry_t       w_head;
  buf_entry_t       w_entry;
  logic             w_xfer;
  logic             w_arrive;
  logic             w_pop;
  logic             w_stall;
  logic             w_room;
  logic [2:0]       w_occ;

  assign vld_out  = (w_held != 2'd0);
  assign data_out = w_head.data;
  assign w_xfer   = vld_out & read_enb;
  assign w_arrive = r_inflight & ~r_soft_reset;
  assign w_pop    = w_xfer & ~r_soft_reset;
  assign w_stall  = vld_out & ~read_enb;

  // held + inflight - xfer + 1 <= 2, moved around so nothing goes negative
  assign w_occ        = {1'b0, w_held} + {2'b00, r_inflight} + 3'd1;
  assign w_room       = (w_occ <= (3'd2 + {2'b00, w_xfer}));
  assign fifo_read_en = resetn & ~fifo_empty & ~r_soft_reset & w_room;

  assign soft_reset = r_soft_reset;
  assign pkt_done   = r_pkt_done;
  assign parity_err = r_parity_err;
  assign busy       = (r_state != HDR) | vld_out | r_inflight;

  always_comb begin
    w_entry.data     = fifo_data;
    w_entry.tag      = (r_state == PAR);
    w_entry.mismatch = (r_state == PAR) && (r_acc != fifo_data);
  end

  out_skid_buf u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .i_flush (r_soft_reset),
    .i_push  (w_arrive),
    .i_pop   (w_pop),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_held  (w_held)
  );

  // Framing advances only on bytes actually arriving from the FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_acc       <= 8'h00;
    end else if (r_soft_reset) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_acc       <= 8'h00;
    end else if (w_arrive) begin
      case (r_state)
        HDR: begin
          r_remaining <= fifo_data[HDR_LEN_MSB:HDR_LEN_LSB];
          r_acc       <= fifo_data;
          r_state     <= (fifo_data[HDR_LEN_MSB:HDR_LEN_LSB] != 6'd0) ? PLD : PAR;
        end
        PLD: begin
          r_acc       <= r_acc ^ fifo_data;
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining == 6'd1) r_state <= PAR;
        end
        PAR:     r_state <= HDR;
        default: r_state <= HDR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_inflight   <= 1'b0;
      r_soft_reset <= 1'b0;
      r_cnt        <= '0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_inflight   <= fifo_read_en;
      r_soft_reset <= ~r_soft_reset & w_stall & (r_cnt == TIMEOUT_M1);
      if (r_soft_reset || !w_stall) r_cnt <= '0;
      else                          r_cnt <= r_cnt + CNT_W'(1);
      r_pkt_done   <= w_pop & w_head.tag;
      r_parity_err <= w_pop & w_head.tag & w_head.mismatch;
    end
  end

endmodule

// File: tb/tb_router_out_port.sv
// Self-checking bench: byte-stream scoreboard, FIFO model and stall-timeout model.
module tb_router_out_port;
  import router_pkg::*;

  localparam int TO = 30;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       read_enb = 1'b0;
  logic       fifo_read_en, soft_reset, vld_out, busy, pkt_done, parity_err;
  logic [7:0] data_out;

  always #5 clock = ~clock;

  router_out_port #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .soft_reset(soft_reset), .read_enb(read_enb),
    .vld_out(vld_out), .data_out(data_out), .busy(busy), .pkt_done(pkt_done),
    .parity_err(parity_err)
  );

  typedef struct { logic [7:0] data; bit is_par; bit err; } exp_t;
  typedef struct {
    logic [7:0] hdr; logic [7:0] pl_mul; logic [7:0] par;
    int mode; bit exp_err; int exp_lat; int exp_span;
  } vec_t;

  exp_t       eq[$];
  logic [7:0] fq[$];
  vec_t       tv[5];
  int  checks = 0, errors = 0;
  int  cyc = 0, outstanding = 0, stall_run = 0, n_done = 0, n_err = 0, mode = 0;
  int  first_x = -1, last_x = -1;
  bit  inflight_prev = 0, pend_done = 0, pend_err = 0, last_err = 0, tog = 0, sr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] pl[], input logic [7:0] par);
    logic [7:0] x;
    x = hdr;
    fq.push_back(hdr);
    eq.push_back('{hdr, 1'b0, 1'b0});
    foreach (pl[i]) begin
      x ^= pl[i];
      fq.push_back(pl[i]);
      eq.push_back('{pl[i], 1'b0, 1'b0});
    end
    fq.push_back(par);
    eq.push_back('{par, 1'b1, (x != par)});
  endtask

  // One clock: drive after negedge, check just before posedge, update FIFO model after it.
  task automatic tick();
    bit   xfer, exp_vld, exp_rd, npd, npe;
    exp_t e;
    case (mode)
      0:       read_enb = 1'b1;
      1:       begin read_enb = tog; tog = ~tog; end
      2:       read_enb = ($urandom_range(3) != 0);
      default: read_enb = 1'b0;
    endcase
    fifo_empty = (fq.size() == 0) || ((mode == 2) && ($urandom_range(4) == 0));
    #4;
    cyc++;
    chk("soft_reset", soft_reset, (stall_run == TO));
    exp_vld = (outstanding - int'(inflight_prev)) > 0;
    chk("vld_out", vld_out, exp_vld);
    xfer = vld_out & read_enb;
    exp_rd = !fifo_empty && !soft_reset && (outstanding - int'(xfer) + 1 <= 2);
    chk("fifo_read_en", fifo_read_en, exp_rd);
    chk("pkt_done", pkt_done, pend_done);
    chk("parity_err", parity_err, pend_done & pend_err);
    if (pkt_done) begin
      n_done++;
      last_err = parity_err;
      if (parity_err) n_err++;
    end
    npd = 0; npe = 0;
    if (soft_reset) begin
      sr_seen = 1;
      fq.delete(); eq.delete();
      outstanding = 0; stall_run = 0;
    end else begin
      if (xfer) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_byte actual=%0h required=none (cycle %0d)", data_out, cyc);
        end else begin
          e = eq.pop_front();
          chk("data_out", data_out, e.data);
          npd = e.is_par; npe = e.err;
        end
        outstanding--;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      stall_run = (vld_out && !read_enb) ? stall_run + 1 : 0;
      if (fifo_read_en) outstanding++;
    end
    inflight_prev = fifo_read_en && !soft_reset;
    @(posedge clock);
    #1;
    if (inflight_prev && fq.size() > 0) fifo_data = fq.pop_front();
    else fifo_data = 8'hzz;
    pend_done = npd; pend_err = npe;
    @(negedge clock);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && n_done < target; i++) tick();
  endtask

  task automatic run_vec(input int v);
    logic [7:0] pl[];
    int nd0, c0;
    pl = new[int'(tv[v].hdr[7:2])];
    foreach (pl[i]) pl[i] = 8'(tv[v].pl_mul * (i + 1));
    mode = tv[v].mode;
    nd0 = n_done; c0 = cyc; first_x = -1;
    push_pkt(tv[v].hdr, pl, tv[v].par);
    tick();
    chk("busy_active", busy, 1'b1);
    wait_done(nd0 + 1, 100);
    chk("vec_done", n_done, nd0 + 1);
    chk("vec_err", last_err, tv[v].exp_err);
    if (tv[v].exp_lat >= 0) begin
      chk("vec_latency", first_x - c0, tv[v].exp_lat);
      chk("vec_span", last_x - first_x, tv[v].exp_span);
    end
    repeat (3) tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_drained", eq.size(), 0);
  endtask

  initial begin
    logic [7:0] pl[];
    logic [7:0] hdr, x, par;
    int len, nd0, ne0, exp_bad;

    // hdr, payload multiplier, parity byte, read mode, parity error?, first-byte latency, span
    tv[0] = '{8'h0C, 8'h11, 8'h0C, 0, 1'b0, 3, 4};
    tv[1] = '{8'h0C, 8'h11, 8'h15, 0, 1'b1, 3, 4};
    tv[2] = '{8'h0C, 8'h11, 8'h14, 0, 1'b1, 3, 4};
    tv[3] = '{8'h02, 8'h00, 8'h02, 0, 1'b0, 3, 1};
    tv[4] = '{8'h28, 8'h01, 8'h23, 1, 1'b0, -1, -1};

    #1 resetn = 1'b0;
    #3;
    chk("rst_vld", vld_out, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_soft_reset", soft_reset, 1'b0);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_read_en", fifo_read_en, 1'b0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(v);

    // client stalls: soft_reset after exactly TO stalled cycles, then clean restart
    mode = 3; sr_seen = 0;
    pl = new[4];
    foreach (pl[i]) pl[i] = 8'(8'h40 + i);
    push_pkt(8'h10, pl, 8'h55);
    for (int i = 0; i < 80 && !sr_seen; i++) tick();
    chk("timeout_fired", sr_seen, 1'b1);
    tick();
    chk("post_sr_vld", vld_out, 1'b0);
    run_vec(0);

    // async reset mid-payload
    mode = 0;
    pl = new[10];
    foreach (pl[i]) pl[i] = 8'(8'hA0 + i);
    push_pkt(8'h28, pl, 8'h00);
    repeat (6) tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_vld", vld_out, 1'b0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_read_en", fifo_read_en, 1'b0);
    chk("arst_pkt_done", pkt_done | parity_err | soft_reset, 1'b0);
    fq.delete(); eq.delete();
    outstanding = 0; stall_run = 0; inflight_prev = 0; pend_done = 0; pend_err = 0;
    fifo_data = 8'h00;
    @(negedge clock);
    resetn = 1'b1;
    run_vec(3);
    run_vec(1);

    // randomized packets against the scoreboard
    mode = 2; nd0 = n_done; ne0 = n_err; exp_bad = 0;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(12);
      hdr = {6'(len), 2'($urandom_range(3))};
      pl = new[len];
      x = hdr;
      foreach (pl[i]) begin
        pl[i] = 8'($urandom);
        x ^= pl[i];
      end
      par = x;
      if ($urandom_range(3) == 0) begin
        par = x ^ 8'($urandom_range(255, 1));
        exp_bad++;
      end
      push_pkt(hdr, pl, par);
    end
    wait_done(nd0 + 30, 4000);
    chk("rand_done", n_done - nd0, 30);
    chk("rand_errs", n_err - ne0, exp_bad);
    mode = 0;
    repeat (3) tick();
    chk("rand_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
